// File: rtl/peaks_readout_pkg.sv
// Package peaks_pkg: the frame type and register map shared by the peaks
// readout block and its FIFO.
// The global widths (`PEAKS, `FINAL_AMPL_WIDTH, `FREQ_WIDTH,
// `TIME_COUNTER_WIDTH) normally come from the project-wide defines. The
// defaults below apply only when a standalone build does not provide them.
`ifndef PEAKS
`define PEAKS 6
`endif
`ifndef FINAL_AMPL_WIDTH
`define FINAL_AMPL_WIDTH 16
`endif
`ifndef FREQ_WIDTH
`define FREQ_WIDTH 10
`endif
`ifndef TIME_COUNTER_WIDTH
`define TIME_COUNTER_WIDTH 24
`endif

package peaks_pkg;

    localparam int PEAKS_N = `PEAKS;
    localparam int AMPL_W  = `FINAL_AMPL_WIDTH;
    localparam int FREQ_W  = `FREQ_WIDTH;
    localparam int TIME_W  = `TIME_COUNTER_WIDTH;

    // One captured frame. The timestamp field is named tm because the
    // word "time" is reserved in SystemVerilog.
    typedef struct packed {
        logic [PEAKS_N-1:0][AMPL_W-1:0] ampl;
        logic [PEAKS_N-1:0][FREQ_W-1:0] freq;
        logic [TIME_W-1:0]              tm;
    } peaks_frame_t;

    // Word addresses of the read-only slave.
    localparam logic [31:0] ADDR_STATUS = 32'd0;
    localparam logic [31:0] ADDR_TIME   = 32'd1;
    localparam logic [31:0] ADDR_AMPL0  = 32'd2;
    localparam logic [31:0] ADDR_FREQ0  = 32'(PEAKS_N + 2);
    localparam logic [31:0] ADDR_POP    = 32'(2 * PEAKS_N + 2);

endpackage

// File: rtl/peaks_readout_fifo.sv
// frame_fifo: DEPTH-entry FIFO of peaks_frame_t.
// Config macro: PEAKS_READOUT_OVERWRITE_EN
//   defined   -> a push into a full FIFO (without a pop) replaces the oldest frame
//   undefined -> a push into a full FIFO (without a pop) is dropped
// Ports:
//   clk, rst_n   clock, async active-low reset
//   push_i       write wdata_i this cycle
//   pop_i        pop request (ignored when empty)
//   wdata_i      frame to push
//   head_o       frame at the read pointer
//   count_o      registered occupancy; count_d_o is its next-state value
//   full_o/empty_o occupancy flags
//   ovf_o        a push hit a full FIFO with no pop in the same cycle
module frame_fifo
    import peaks_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  peaks_frame_t  wdata_i,
    output peaks_frame_t  head_o,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] count_d_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          ovf_o
);

    peaks_frame_t  mem [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          we, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        we      = 1'b0;
        ovf_o   = 1'b0;
        if (push_i && full_o && !pop_ok) begin
            ovf_o = 1'b1;
`ifdef PEAKS_READOUT_OVERWRITE_EN
            // Full means wr == rd, so writing at wr replaces the oldest frame
            // and moving rd forward exposes the next oldest.
            we   = 1'b1;
            wr_d = wr_q + PW'(1);
            rd_d = rd_q + PW'(1);
`endif
        end else begin
            // With a pop, the slot is freed before the push claims it, so
            // push+pop on a full FIFO is legal.
            if (pop_ok) rd_d = rd_q + PW'(1);
            if (push_i) begin
                we   = 1'b1;
                wr_d = wr_q + PW'(1);
            end
            if (push_i && !pop_ok)      count_d = count_q + CW'(1);
            else if (!push_i && pop_ok) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset; reads are gated by empty in the top.
    always_ff @(posedge clk) begin
        if (we) mem[wr_q] <= wdata_i;
    end

    assign head_o    = mem[rd_q];
    assign count_o   = count_q;
    assign count_d_o = count_d;

endmodule

// File: rtl/peaks_readout.sv
// peaks_readout: buffers peaks frames and exposes the oldest one on a
// read-only Avalon-MM slave to the HPS.
// Config macro: PEAKS_READOUT_OVERWRITE_EN (overwrite-oldest on overflow).
// Ports:
//   clk, reset      clock, async active-low reset
//   valid_in        1-cycle pulse; amplitudes_in/freqs_in/counter_in valid
//   chipselect,read Avalon read strobe, address = word address
//   readdata        registered read data, 1-cycle latency, held when idle
//   irq             high while frames are pending
// Map: 0 STATUS {ovf,0,count}, 1 TIME, AMPL[i], FREQ[i], POP; others read 0.
module peaks_readout
    import peaks_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            valid_in,
    input  logic [PEAKS_N-1:0][AMPL_W-1:0]  amplitudes_in,
    input  logic [PEAKS_N-1:0][FREQ_W-1:0]  freqs_in,
    input  logic [TIME_W-1:0]               counter_in,
    input  logic                            chipselect,
    input  logic                            read,
    input  logic [ADDR_W-1:0]               address,
    output logic [31:0]                     readdata,
    output logic                            irq
);

    localparam int CW = $clog2(DEPTH + 1);

    peaks_frame_t  wframe, head;
    logic [CW-1:0] count, count_nxt;
    logic          full, empty, fifo_ovf;
    logic          rd_en, pop_req, status_rd;
    logic [31:0]   addr32;
    logic [31:0]   rdata_q, rdata_d;
    logic          ovf_q, ovf_d;
    logic          irq_q;

    assign wframe.ampl = amplitudes_in;
    assign wframe.freq = freqs_in;
    assign wframe.tm   = counter_in;

    assign addr32    = 32'(address);
    assign rd_en     = chipselect & read;
    assign pop_req   = rd_en & (addr32 == ADDR_POP);
    assign status_rd = rd_en & (addr32 == ADDR_STATUS);

    frame_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push_i    (valid_in),
        .pop_i     (pop_req),
        .wdata_i   (wframe),
        .head_o    (head),
        .count_o   (count),
        .count_d_o (count_nxt),
        .full_o    (full),
        .empty_o   (empty),
        .ovf_o     (fifo_ovf)
    );

    // A new overflow in the same cycle as a STATUS read survives the clear.
    assign ovf_d = (status_rd ? 1'b0 : ovf_q) | fifo_ovf;

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = '0;
            if (addr32 == ADDR_STATUS) begin
                rdata_d = {ovf_q, 23'b0, 8'(count)};
            end else if (addr32 == ADDR_POP) begin
                rdata_d = {31'b0, ~empty};
            end else if (!empty) begin
                if (addr32 == ADDR_TIME) rdata_d = 32'(head.tm);
                for (int i = 0; i < PEAKS_N; i++) begin
                    if (addr32 == ADDR_AMPL0 + 32'(i))
                        rdata_d = 32'($signed(head.ampl[i]));
                    if (addr32 == ADDR_FREQ0 + 32'(i))
                        rdata_d = 32'(head.freq[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
            irq_q   <= (count_nxt != '0);
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;

    logic unused;
    assign unused = full;

endmodule

// File: tb/tb_peaks_readout.sv
module tb_peaks_readout;
    import peaks_pkg::*;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 4;

    logic                           clk = 1'b0;
    logic                           reset = 1'b0;
    logic                           valid_in = 1'b0;
    logic [PEAKS_N-1:0][AMPL_W-1:0] amplitudes_in = '0;
    logic [PEAKS_N-1:0][FREQ_W-1:0] freqs_in = '0;
    logic [TIME_W-1:0]              counter_in = '0;
    logic                           chipselect = 1'b0;
    logic                           read = 1'b0;
    logic [ADDR_W-1:0]              address = '0;
    logic [31:0]                    readdata;
    logic                           irq;

    peaks_readout #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .amplitudes_in(amplitudes_in), .freqs_in(freqs_in), .counter_in(counter_in),
        .chipselect(chipselect), .read(read), .address(address),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of frames, an overflow flag, the expected
    // readdata register.
    peaks_frame_t mq[$];
    logic         m_ovf = 1'b0;
    logic [31:0]  exp_rd = '0;

    localparam int A_STATUS = 0;
    localparam int A_TIME   = 1;
    localparam int A_AMPL0  = 2;
    localparam int A_FREQ0  = PEAKS_N + 2;
    localparam int A_POP    = 2 * PEAKS_N + 2;

    function automatic logic [31:0] model_read(input int a);
        int v;
        if (a == A_STATUS) return {m_ovf, 23'b0, 8'(mq.size())};
        if (a == A_POP) return (mq.size() != 0) ? 32'd1 : 32'd0;
        if (mq.size() == 0) return 32'd0;
        if (a == A_TIME) return 32'(mq[0].tm);
        if (a >= A_AMPL0 && a < A_AMPL0 + PEAKS_N) begin
            v = int'(mq[0].ampl[a - A_AMPL0]);
            if (v >= (1 << (AMPL_W - 1))) v = v - (1 << AMPL_W);
            return 32'(v);
        end
        if (a >= A_FREQ0 && a < A_FREQ0 + PEAKS_N) return 32'(mq[0].freq[a - A_FREQ0]);
        return 32'd0;
    endfunction

    function automatic peaks_frame_t rand_frame();
        peaks_frame_t f;
        for (int i = 0; i < PEAKS_N; i++) begin
            f.ampl[i] = AMPL_W'($urandom);
            f.freq[i] = FREQ_W'($urandom);
        end
        f.tm = TIME_W'($urandom);
        return f;
    endfunction

    // One bus cycle: drive, update the model, clock, release strobes.
    // Afterwards readdata/irq are sampled 1 time unit past the edge.
    task automatic cycle(input logic v, input peaks_frame_t f, input logic cs,
                         input logic rd, input int a);
        logic acc, pop_eff, full;
        valid_in      = v;
        amplitudes_in = f.ampl;
        freqs_in      = f.freq;
        counter_in    = f.tm;
        chipselect    = cs;
        read          = rd;
        address       = ADDR_W'(a);
        acc     = cs & rd;
        if (acc) exp_rd = model_read(a);
        pop_eff = acc && (a == A_POP) && (mq.size() != 0);
        full    = (mq.size() == DEPTH);
        if (acc && a == A_STATUS) m_ovf = 1'b0;
        if (pop_eff) void'(mq.pop_front());
        if (v) begin
            if (!full || pop_eff) mq.push_back(f);
            else begin
                m_ovf = 1'b1;
`ifdef PEAKS_READOUT_OVERWRITE_EN
                void'(mq.pop_front());
                mq.push_back(f);
`endif
            end
        end
        @(posedge clk); #1;
        valid_in   = 1'b0;
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mq.delete();
        m_ovf  = 1'b0;
        exp_rd = '0;
        #13;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        peaks_frame_t z = '0;
        do_reset();
        if (readdata !== 32'd0) begin $display("FAIL reset_readdata got=%h exp=0", readdata); fails++; end
        tests++;
        if (irq !== 1'b0) begin $display("FAIL reset_irq got=%b exp=0", irq); fails++; end
        tests++;
        cycle(0, z, 1, 1, A_STATUS);
        if (readdata !== 32'h0 || readdata !== exp_rd) begin
            $display("FAIL reset_status got=%h exp=00000000", readdata); fails++;
        end
        tests++;
    endtask

    task automatic test_basic();
        peaks_frame_t f = '0;
        peaks_frame_t z = '0;
        int fr[PEAKS_N];
        fr = '{1, 3, 5, 8, 12, 15};
        for (int i = 0; i < PEAKS_N; i++) begin
            f.ampl[i] = AMPL_W'(i + 1);
            f.freq[i] = FREQ_W'(fr[i]);
        end
        f.tm = TIME_W'(5);
        cycle(1, f, 0, 0, 0);
        if (irq !== 1'b1) begin $display("FAIL basic_irq got=%b exp=1", irq); fails++; end
        tests++;
        cycle(0, z, 1, 1, A_STATUS);
        if (readdata !== 32'd1) begin $display("FAIL basic_status got=%h exp=1", readdata); fails++; end
        tests++;
        cycle(0, z, 1, 1, A_TIME);
        if (readdata !== 32'd5) begin $display("FAIL basic_time got=%h exp=5", readdata); fails++; end
        tests++;
        for (int i = 0; i < PEAKS_N; i++) begin
            cycle(0, z, 1, 1, A_AMPL0 + i);
            if (readdata !== 32'(i + 1)) begin
                $display("FAIL basic_ampl%0d got=%h exp=%h", i, readdata, 32'(i + 1)); fails++;
            end
            tests++;
            cycle(0, z, 1, 1, A_FREQ0 + i);
            if (readdata !== 32'(fr[i])) begin
                $display("FAIL basic_freq%0d got=%h exp=%h", i, readdata, 32'(fr[i])); fails++;
            end
            tests++;
        end
        // chipselect without read must hold readdata
        cycle(0, z, 1, 0, A_STATUS);
        if (readdata !== 32'(fr[PEAKS_N-1])) begin
            $display("FAIL basic_hold got=%h exp=%h", readdata, 32'(fr[PEAKS_N-1])); fails++;
        end
        tests++;
        cycle(0, z, 1, 1, A_POP);
        if (readdata !== 32'd1) begin $display("FAIL basic_pop got=%h exp=1", readdata); fails++; end
        tests++;
        if (irq !== 1'b0) begin $display("FAIL basic_irq_after_pop got=%b exp=0", irq); fails++; end
        tests++;
        cycle(0, z, 1, 1, A_STATUS);
        if (readdata !== 32'd0) begin $display("FAIL basic_status_after_pop got=%h exp=0", readdata); fails++; end
        tests++;
    endtask

    task automatic test_sign();
        peaks_frame_t f = rand_frame();
        peaks_frame_t z = '0;
        f.ampl[0] = AMPL_W'(-8);
        cycle(1, f, 0, 0, 0);
        cycle(0, z, 1, 1, A_AMPL0);
        if (readdata !== 32'hFFFF_FFF8) begin
            $display("FAIL sign_ampl0 got=%h exp=fffffff8", readdata); fails++;
        end
        tests++;
        cycle(0, z, 1, 1, A_POP);
    endtask

    task automatic test_overflow();
        peaks_frame_t f;
        peaks_frame_t z = '0;
        logic [31:0] exp_head;
        for (int t = 1; t <= 9; t++) begin
            f = rand_frame();
            f.tm = TIME_W'(t);
            cycle(1, f, 0, 0, 0);
        end
        cycle(0, z, 1, 1, A_STATUS);
        if (readdata !== 32'h8000_0008) begin
            $display("FAIL ovf_status got=%h exp=80000008", readdata); fails++;
        end
        tests++;
`ifdef PEAKS_READOUT_OVERWRITE_EN
        exp_head = 32'd2;
`else
        exp_head = 32'd1;
`endif
        cycle(0, z, 1, 1, A_TIME);
        if (readdata !== exp_head) begin
            $display("FAIL ovf_head_time got=%h exp=%h", readdata, exp_head); fails++;
        end
        tests++;
        cycle(0, z, 1, 1, A_STATUS);
        if (readdata !== 32'h0000_0008) begin
            $display("FAIL ovf_status_cleared got=%h exp=00000008", readdata); fails++;
        end
        tests++;
    endtask

    task automatic test_push_pop_full();
        peaks_frame_t f = rand_frame();
        peaks_frame_t z = '0;
        logic [31:0] exp_next;
        exp_next = 32'(mq[1].tm);
        cycle(1, f, 1, 1, A_POP);
        if (readdata !== 32'd1) begin $display("FAIL pp_pop got=%h exp=1", readdata); fails++; end
        tests++;
        cycle(0, z, 1, 1, A_STATUS);
        if (readdata !== 32'h0000_0008) begin
            $display("FAIL pp_status got=%h exp=00000008", readdata); fails++;
        end
        tests++;
        cycle(0, z, 1, 1, A_TIME);
        if (readdata !== exp_next) begin
            $display("FAIL pp_head got=%h exp=%h", readdata, exp_next); fails++;
        end
        tests++;
    endtask

    task automatic test_empty_reset();
        peaks_frame_t z = '0;
        while (mq.size() != 0) cycle(0, z, 1, 1, A_POP);
        cycle(0, z, 1, 1, A_TIME);
        if (readdata !== 32'd0) begin $display("FAIL empty_time got=%h exp=0", readdata); fails++; end
        tests++;
        cycle(0, z, 1, 1, A_AMPL0);
        if (readdata !== 32'd0) begin $display("FAIL empty_ampl got=%h exp=0", readdata); fails++; end
        tests++;
        cycle(0, z, 1, 1, A_POP);
        if (readdata !== 32'd0) begin $display("FAIL empty_pop got=%h exp=0", readdata); fails++; end
        tests++;
        for (int i = 0; i < 3; i++) cycle(1, rand_frame(), 0, 0, 0);
        cycle(0, z, 1, 1, A_TIME);
        do_reset();
        if (irq !== 1'b0) begin $display("FAIL midreset_irq got=%b exp=0", irq); fails++; end
        tests++;
        cycle(0, z, 1, 1, A_STATUS);
        if (readdata !== 32'd0) begin $display("FAIL midreset_status got=%h exp=0", readdata); fails++; end
        tests++;
    endtask

    task automatic test_random();
        int a, nbad;
        logic v, cs, rd;
        nbad = 0;
        for (int n = 0; n < 600; n++) begin
            v  = ($urandom_range(0, 2) == 0);
            cs = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 3) != 0);
            a  = ($urandom_range(0, 3) == 0) ? A_POP : $urandom_range(0, (1 << ADDR_W) - 1);
            cycle(v, rand_frame(), cs, rd, a);
            if (readdata !== exp_rd) begin
                if (nbad < 10) $display("FAIL rand_readdata cyc=%0d addr=%0d got=%h exp=%h", n, a, readdata, exp_rd);
                nbad++; fails++;
            end
            tests++;
            if (irq !== (mq.size() != 0)) begin
                if (nbad < 10) $display("FAIL rand_irq cyc=%0d got=%b exp=%b", n, irq, mq.size() != 0);
                nbad++; fails++;
            end
            tests++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign();
        test_overflow();
        test_push_pop_full();
        test_empty_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
